delay_buffer_ctrl: RTL
======================

// Module: delay_buffer_ctrl
// PURPOSE
//  Sequencer in front of one delay_buffer instance. Accepts runtime delay reconfiguration
//  via valid/ready handshake, flushes the buffer, then gates the input stream into it.
//  Qualifies buffer output: the first <delay> outputs after a flush are discarded. On request,
//  drains in-flight samples by injecting zero bubbles before applying the new delay.
// PARAMETERS
//  MAX_DELAY  128  depth of the controlled delay_buffer; delay range 0..MAX_DELAY-1
//  WIDTH      32   sample width
// PORTS
//  clk          in   1                  clock
//  rst          in   1                  synchronous, active-high reset
//  cfg_valid    in   1                  new delay request
//  cfg_ready    out  1                  request accepted when cfg_valid & cfg_ready
//  cfg_delay    in   $clog2(MAX_DELAY)  requested delay in samples
//  cfg_drain    in   1                  sampled with cfg: 1 = drain before reconfig
//  in_valid     in   1                  upstream sample valid
//  in_ready     out  1                  upstream may transfer (in_valid & in_ready)
//  in_data      in   WIDTH              upstream sample
//  buf_valid_in out  1                  to delay_buffer valid_in (push)
//  buf_data_in  out  WIDTH              to delay_buffer data_in
//  buf_flush    out  1                  to delay_buffer flush
//  buf_delay    out  $clog2(MAX_DELAY)  to delay_buffer delay (registered, stable outside FLUSH)
//  out_valid    out  1                  buffer data_out holds a real, aligned sample this cycle
//  busy         out  1                  state != RUN
// BEHAVIOUR
//  States: IDLE, FLUSH, FILL, RUN, DRAIN. Reset -> IDLE; all outputs 0, buf_delay=0, count=0.
//  IDLE : cfg_ready=1, in_ready=0. Accept -> latch delay; FLUSH (cfg_drain ignored in IDLE).
//  FLUSH: exactly 1 cycle; buf_flush=1, buf_delay<=latched delay, count<=0, in_ready=0 -> FILL.
//  FILL : in_ready=1; buf_valid_in=in_valid, buf_data_in=in_data. Each push: count++.
//         Push with count==delay (or delay==0) -> RUN on the next cycle. cfg_ready=1.
//  RUN  : in_ready=1, pass-through as FILL; count held. cfg_ready=1.
//  Accept in FILL/RUN: cfg_drain=0 -> FLUSH (contents discarded); cfg_drain=1 & RUN -> DRAIN;
//         cfg_drain=1 & FILL -> FLUSH (nothing qualified to drain). Pushes in the accept cycle
//         complete normally; new delay latched in a pending reg, applied in FLUSH.
//  DRAIN: in_ready=0, cfg_ready=0; buf_valid_in=1, buf_data_in=0 for exactly old delay cycles
//         (0 cycles if delay==0 -> straight to FLUSH); down-counter; at 0 -> FLUSH.
//  Qualification: push index k (count before increment) is qualified iff k>=delay (FILL) or
//         always (RUN, DRAIN). out_valid is registered: out_valid(t+1)=buf_valid_in(t) & qual(t),
//         matching the buffer's 1-cycle read latency. Bubbles never qualify their own slot data;
//         they qualify the old sample they pop.
//  count width $clog2(MAX_DELAY)+1; saturates at delay, never wraps.
//  Simultaneous cfg accept and push: push counted under the old delay, then reconfig.
//  rst mid-operation: returns to IDLE next cycle; buf_flush not asserted by rst (buffer has own
//  reset); first cfg after rst always goes through FLUSH.
//  cfg_ready=0 in FLUSH and DRAIN; cfg_valid may stay high and is accepted later.
// STRUCTURE
//  delay_buffer_pkg: typedef enum logic [2:0] dbc_state_t {IDLE,FLUSH,FILL,RUN,DRAIN};
//  delay width constant function. Single module, no sub-modules; optional top-level
//  wrapper delay_buffer_sys instantiating delay_buffer_ctrl + delay_buffer for the bench.
// TESTING (bench uses delay_buffer_sys, scoreboard = ideal delay line)
//  1 rst, cfg delay=4, push 0..19 back-to-back -> out_valid for outputs 0..15, first aligned
//    to push 4; pushes 0..3 produce no out_valid; busy drops after push index 4.
//  2 delay=0 -> out_valid one cycle after every push, data==in_data; FILL->RUN on first push.
//  3 RUN delay=3, cfg delay=5 drain=1 -> 3 zero bubbles, out_valid on last 3 old samples,
//    in_ready=0 for 3 DRAIN + 1 FLUSH cycles, then 5 unqualified pushes under new delay.
//  4 RUN, cfg drain=0 with simultaneous push -> push counted, 1-cycle flush, no stale
//    out_valid afterwards; sparse in_valid (1 of 3 cycles) keeps alignment.
//  5 delay=MAX_DELAY-1 (127), push 300 -> first out_valid at push 127, count saturates, no wrap.
//  6 rst asserted in DRAIN and in FILL -> IDLE, in_ready=0, out_valid=0 next cycle; cfg_valid
//    held high across FLUSH/DRAIN is accepted exactly once.

Source files
------------

// File: rtl/delay_buffer_pkg.sv
// Shared types and sizing helpers for the delay_buffer sequencer.
package delay_buffer_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    FILL  = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } dbc_state_t;

  function automatic int delay_width(input int max_delay);
    return (max_delay > 1) ? $clog2(max_delay) : 1;
  endfunction

endpackage

// File: rtl/delay_buffer_ctrl.sv
// Sequencer in front of a delay_buffer: reconfigures delay, flushes, fills, qualifies
// the buffer output and optionally drains in-flight samples with zero bubbles.
module delay_buffer_ctrl
  import delay_buffer_pkg::*;
#(
  parameter int MAX_DELAY = 128,
  parameter int WIDTH     = 32,
  localparam int DW       = delay_width(MAX_DELAY)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [DW-1:0]    cfg_delay,
  input  logic             cfg_drain,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             buf_valid_in,
  output logic [WIDTH-1:0] buf_data_in,
  output logic             buf_flush,
  output logic [DW-1:0]    buf_delay,
  output logic             out_valid,
  output logic             busy,
  output dbc_state_t       dbg_state
);

  localparam int CW = DW + 1;

  // Handshake: a transfer happens on a cycle where valid & ready are both high at posedge.
  dbc_state_t       r_state;
  dbc_state_t       w_next;
  logic [DW-1:0]    r_pending;
  logic [DW-1:0]    r_buf_delay;
  logic [CW-1:0]    r_count;
  logic [DW-1:0]    r_drain_cnt;
  logic             r_out_valid;

  logic             w_cfg_ready;
  logic             w_in_ready;
  logic             w_bvi;
  logic [WIDTH-1:0] w_bdi;
  logic             w_flush;
  logic             w_qual;
  logic             w_accept;
  logic             w_push;

  assign w_accept = cfg_valid & w_cfg_ready;
  assign w_push   = w_bvi;

  always_comb begin
    w_next      = r_state;
    w_cfg_ready = 1'b0;
    w_in_ready  = 1'b0;
    w_bvi       = 1'b0;
    w_bdi       = '0;
    w_flush     = 1'b0;
    w_qual      = 1'b0;
    case (r_state)
      IDLE: begin
        w_cfg_ready = 1'b1;
        if (cfg_valid) w_next = FLUSH;
      end
      FLUSH: begin
        w_flush = 1'b1;
        w_next  = FILL;
      end
      FILL: begin
        w_cfg_ready = 1'b1;
        w_in_ready  = 1'b1;
        w_bvi       = in_valid;
        w_bdi       = in_data;
        // count saturates at the delay, so >= also covers a zero delay
        w_qual      = (r_count >= {1'b0, r_buf_delay});
        if (cfg_valid)
          w_next = FLUSH;
        else if (in_valid && w_qual)
          w_next = RUN;
      end
      RUN: begin
        w_cfg_ready = 1'b1;
        w_in_ready  = 1'b1;
        w_bvi       = in_valid;
        w_bdi       = in_data;
        w_qual      = 1'b1;
        if (cfg_valid)
          w_next = (cfg_drain && (r_buf_delay != '0)) ? DRAIN : FLUSH;
      end
      DRAIN: begin
        w_bvi  = 1'b1;
        w_qual = 1'b1;
        if (r_drain_cnt <= DW'(1)) w_next = FLUSH;
      end
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_pending   <= '0;
      r_buf_delay <= '0;
      r_count     <= '0;
      r_drain_cnt <= '0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_out_valid <= w_push & w_qual;
      if (w_accept) r_pending <= cfg_delay;
      case (r_state)
        FLUSH: begin
          r_buf_delay <= r_pending;
          r_count     <= '0;
        end
        FILL: begin
          if (w_push && (r_count < {1'b0, r_buf_delay})) r_count <= r_count + 1'b1;
        end
        RUN: begin
          if (w_accept && cfg_drain) r_drain_cnt <= r_buf_delay;
        end
        DRAIN: begin
          r_drain_cnt <= r_drain_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign cfg_ready    = w_cfg_ready;
  assign in_ready     = w_in_ready;
  assign buf_valid_in = w_bvi;
  assign buf_data_in  = w_bdi;
  assign buf_flush    = w_flush;
  assign buf_delay    = r_buf_delay;
  assign out_valid    = r_out_valid;
  assign busy         = (r_state != RUN);
  assign dbg_state    = r_state;

endmodule
